// File: rtl/adc_sched_pkg.sv
// ---------------------------------------------------------------------------
// adc_sched_pkg
// Shared types for the ADC conversion scheduler and the menu FSM.
//   NUM_ADC        : number of ADC front-ends served by the scheduler
//   adc_id_t       : ADC select code (also the bit index into conv_done)
//   sched_state_t  : scheduler FSM states
//   adc_onehot()   : select code -> one-hot enable vector
// ---------------------------------------------------------------------------
package adc_sched_pkg;

  localparam int NUM_ADC = 4;

  typedef enum logic [1:0] {
    ADC_PWM  = 2'd0,
    ADC_R2R  = 2'd1,
    ADC_SAR  = 2'd2,
    ADC_XADC = 2'd3
  } adc_id_t;

  typedef enum logic [2:0] {
    ST_GUARD,
    ST_SETTLE,
    ST_WAIT_PERIOD,
    ST_START,
    ST_WAIT_DONE
  } sched_state_t;

  function automatic logic [NUM_ADC-1:0] adc_onehot(input adc_id_t id);
    return NUM_ADC'(1) << id;
  endfunction

endpackage

// File: rtl/adc_conv_scheduler_if.sv
// ---------------------------------------------------------------------------
// adc_conv_scheduler_if
// Bundles the scheduler's menu, ADC front-end and sample-stream signals.
//   master : the scheduler (drives enables, conv_start, sample stream)
//   slave  : the environment (drives adc_sel, conv_done, conv_data)
// Parameter DATA_W : sample width; conv_data carries NUM_ADC slices.
// ---------------------------------------------------------------------------
interface adc_conv_scheduler_if #(
  parameter int DATA_W = 12
);
  import adc_sched_pkg::*;

  logic [1:0]              adc_sel;
  logic [NUM_ADC-1:0]      conv_done;
  logic [NUM_ADC*DATA_W-1:0] conv_data;
  logic                    pwm_en;
  logic                    r2r_en;
  logic                    sar_en;
  logic                    xadc_en;
  logic                    conv_start;
  logic [DATA_W-1:0]       sample_data;
  logic [1:0]              sample_src;
  logic                    sample_valid;
  logic                    timeout_err;
  logic                    busy;

  modport master (
    input  adc_sel, conv_done, conv_data,
    output pwm_en, r2r_en, sar_en, xadc_en, conv_start,
           sample_data, sample_src, sample_valid, timeout_err, busy
  );

  modport slave (
    output adc_sel, conv_done, conv_data,
    input  pwm_en, r2r_en, sar_en, xadc_en, conv_start,
           sample_data, sample_src, sample_valid, timeout_err, busy
  );

endinterface

// File: rtl/adc_conv_scheduler_timer.sv
// ---------------------------------------------------------------------------
// sched_timer
// Loadable down-counter. Loading value N-1 makes expired_o rise exactly N
// cycles later; the counter then holds at zero until reloaded.
//   clk, reset   : clock, asynchronous active-low reset (count = RST_VAL)
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value to load
//   expired_o    : count is zero
// ---------------------------------------------------------------------------
module sched_timer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - WIDTH'(1);
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/adc_conv_scheduler.sv
// ---------------------------------------------------------------------------
// adc_conv_scheduler
// Drives exactly one ADC enable from the menu selection, with a dead-time
// guard and settling delay on every switch, issues periodic conv_start
// pulses, collects results with a timeout and emits one sample stream.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : adc_conv_scheduler_if.master (adc_sel, conv_done, conv_data
//                in; enables, conv_start, sample_*, timeout_err, busy out)
// Build option: define ADC_SCHED_AVG_EN to output the mean of every four
// valid conversions instead of each conversion.
// ---------------------------------------------------------------------------
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int SAMPLE_PERIOD  = 100_000,
  parameter int GUARD_CYCLES   = 16,
  parameter int SETTLE_CYCLES  = 1_000,
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int DATA_W         = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  adc_conv_scheduler_if.master bus
);

  localparam int GS_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int GS_W   = $clog2(GS_MAX + 1);
  localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  // Timers count N-1 .. 0 so that a phase lasts exactly N cycles.
  localparam logic [GS_W-1:0]  GUARD_LD  = GS_W'(GUARD_CYCLES - 1);
  localparam logic [GS_W-1:0]  SETTLE_LD = GS_W'(SETTLE_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LD    = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LD     = TO_W'(TIMEOUT_CYCLES - 1);

  sched_state_t        state_q, state_d;
  adc_id_t             sel_q, act_q, act_d;
  logic [NUM_ADC-1:0]  en_q, en_d;
  logic                start_q, busy_q, valid_q, valid_d, terr_q, terr_d;
  logic [DATA_W-1:0]   data_q, data_d, data_sel;
  adc_id_t             src_q, src_d;
  logic                conv_hit, to_hit, guard_entry;
  logic                gs_load, gs_exp, per_exp, to_exp, start_load;
  logic [GS_W-1:0]     gs_val;

  assign data_sel = bus.conv_data[int'(act_q)*DATA_W +: DATA_W];

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    conv_hit = 1'b0;
    to_hit   = 1'b0;
    unique case (state_q)
      ST_GUARD: begin
        // adc_sel changes here are simply picked up at expiry.
        if (gs_exp) begin
          act_d   = sel_q;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sel_q != act_q) state_d = ST_GUARD;
        else if (gs_exp)    state_d = ST_START;
      end
      ST_START: begin
        state_d = (sel_q != act_q) ? ST_GUARD : ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Abort wins over a same-cycle done so the in-flight result is dropped.
        if (sel_q != act_q) begin
          state_d = ST_GUARD;
        end else if (bus.conv_done[act_q] || to_exp) begin
          conv_hit = bus.conv_done[act_q];
          to_hit   = !bus.conv_done[act_q];
          // Period already elapsed: exactly one owed start, taken immediately.
          state_d  = per_exp ? ST_START : ST_WAIT_PERIOD;
        end
      end
      ST_WAIT_PERIOD: begin
        if (sel_q != act_q) state_d = ST_GUARD;
        else if (per_exp)   state_d = ST_START;
      end
      default: state_d = ST_GUARD;
    endcase
  end

  assign guard_entry = (state_d == ST_GUARD) && (state_q != ST_GUARD);
  assign gs_load     = guard_entry || ((state_d == ST_SETTLE) && (state_q != ST_SETTLE));
  assign gs_val      = guard_entry ? GUARD_LD : SETTLE_LD;
  // Loading on START entry makes successive starts exactly SAMPLE_PERIOD apart.
  assign start_load  = (state_d == ST_START);

  // Enables follow the next state, so they only move on GUARD entry/exit.
  assign en_d = (state_d == ST_GUARD) ? '0 : adc_onehot(act_d);

  // ---------------- sample path ----------------
`ifdef ADC_SCHED_AVG_EN
  logic [DATA_W+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]        avg_cnt_q, avg_cnt_d;

  always_comb begin
    valid_d   = 1'b0;
    data_d    = data_q;
    src_d     = src_q;
    terr_d    = terr_q | to_hit;
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + {2'b00, data_sel};
    if (guard_entry || to_hit) begin
      acc_d     = '0;
      avg_cnt_d = '0;
    end else if (conv_hit) begin
      if (avg_cnt_q == 2'd3) begin
        valid_d   = 1'b1;
        data_d    = acc_sum[DATA_W+1:2];
        src_d     = act_q;
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  always_comb begin
    valid_d = conv_hit;
    data_d  = conv_hit ? data_sel : data_q;
    src_d   = conv_hit ? act_q : src_q;
    terr_d  = terr_q | to_hit;
  end
`endif

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_GUARD;
      sel_q   <= ADC_PWM;
      act_q   <= ADC_PWM;
      en_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= ADC_PWM;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= adc_id_t'(bus.adc_sel);
      act_q   <= act_d;
      en_q    <= en_d;
      start_q <= (state_d == ST_START);
      busy_q  <= (state_d == ST_GUARD) || (state_d == ST_SETTLE) ||
                 (state_d == ST_WAIT_DONE);
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      terr_q  <= terr_d;
    end
  end

  // ---------------- timers ----------------
  sched_timer #(.WIDTH(GS_W), .RST_VAL(GUARD_LD)) u_gs_timer (
    .clk(clk), .reset(reset), .load_i(gs_load), .load_val_i(gs_val), .expired_o(gs_exp)
  );

  sched_timer #(.WIDTH(PER_W), .RST_VAL('0)) u_per_timer (
    .clk(clk), .reset(reset), .load_i(start_load), .load_val_i(PER_LD), .expired_o(per_exp)
  );

  sched_timer #(.WIDTH(TO_W), .RST_VAL('0)) u_to_timer (
    .clk(clk), .reset(reset), .load_i(start_load), .load_val_i(TO_LD), .expired_o(to_exp)
  );

  // ---------------- outputs ----------------
  assign bus.pwm_en       = en_q[ADC_PWM];
  assign bus.r2r_en       = en_q[ADC_R2R];
  assign bus.sar_en       = en_q[ADC_SAR];
  assign bus.xadc_en      = en_q[ADC_XADC];
  assign bus.conv_start   = start_q;
  assign bus.busy         = busy_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_data  = data_q;
  assign bus.sample_src   = src_q;
  assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_conv_scheduler
// Directed bench for adc_conv_scheduler (default build, averaging off).
// dut_a: PERIOD=100 GUARD=16 SETTLE=1000 TIMEOUT=50 -- start-up, periodic
//        conversions, timeout, ADC switch.
// dut_b: PERIOD=100 GUARD=4 SETTLE=10 TIMEOUT=500 -- done arriving after
//        the period has already elapsed.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_conv_scheduler;
  import adc_sched_pkg::*;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_conv_scheduler_if #(.DATA_W(DW)) a_if ();
  adc_conv_scheduler_if #(.DATA_W(DW)) b_if ();

  adc_conv_scheduler #(
    .SAMPLE_PERIOD(100), .GUARD_CYCLES(16), .SETTLE_CYCLES(1000),
    .TIMEOUT_CYCLES(50), .DATA_W(DW)
  ) dut_a (.clk(clk), .reset(reset), .bus(a_if));

  adc_conv_scheduler #(
    .SAMPLE_PERIOD(100), .GUARD_CYCLES(4), .SETTLE_CYCLES(10),
    .TIMEOUT_CYCLES(500), .DATA_W(DW)
  ) dut_b (.clk(clk), .reset(reset), .bus(b_if));

  typedef struct {
    int          delay;      // cycles from conv_start to the done pulse
    logic [3:0]  mask;       // conv_done bits pulsed
    logic [11:0] data;       // value placed on the active ADC slice
    logic        exp_valid;  // sample_valid expected the cycle after done
  } conv_vec_t;

  conv_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  // Active ADC slice carries d; the others carry ~d so a wrong slice shows.
  function automatic logic [4*DW-1:0] mk_data(input adc_id_t id, input logic [DW-1:0] d);
    logic [4*DW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*DW +: DW] = (i == int'(id)) ? d : ~d;
    return r;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return a_if.conv_start;
      1:       return a_if.pwm_en;
      2:       return a_if.sar_en;
      3:       return b_if.conv_start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output int n);
    n = 0;
    while (!sig(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    int          t_start, t2;
    logic        vseen;
    logic [11:0] exp_last;

    vecs[0] = '{10, 4'b0001, 12'hABC, 1'b1};
    vecs[1] = '{10, 4'b0001, 12'hABC, 1'b1};
    vecs[2] = '{ 1, 4'b0001, 12'h000, 1'b1};  // earliest possible done
    vecs[3] = '{49, 4'b0001, 12'hFFF, 1'b1};  // done on the timeout-expiry cycle
    vecs[4] = '{10, 4'b1110, 12'h555, 1'b0};  // only foreign bits -> timeout
    vecs[5] = '{10, 4'b1111, 12'h123, 1'b1};  // active bit among others
    vecs[6] = '{30, 4'b0001, 12'h7FF, 1'b1};

    reset = 1'b0;
    a_if.adc_sel = 2'd0; a_if.conv_done = '0; a_if.conv_data = '0;
    b_if.adc_sel = 2'd0; b_if.conv_done = '0; b_if.conv_data = '0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst enables", {a_if.pwm_en, a_if.r2r_en, a_if.sar_en, a_if.xadc_en}, 0);
    check("rst conv_start", a_if.conv_start, 0);
    check("rst sample_valid", a_if.sample_valid, 0);
    check("rst sample_data", a_if.sample_data, 0);
    check("rst sample_src", a_if.sample_src, 0);
    check("rst timeout_err", a_if.timeout_err, 0);
    check("rst busy", a_if.busy, 1);

    // ---- start-up: guard then settle ----
    reset = 1'b1;
    wait_sig(1, 100, n);
    check("pwm_en after reset", n, 16);
    check("busy in settle", a_if.busy, 1);
    wait_sig(0, 1100, n);
    check("first start after settle", n, 1000);
    check("busy in start", a_if.busy, 0);
    t_start  = cyc;
    exp_last = 12'h000;

    // ---- periodic conversions ----
    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].delay) @(negedge clk);
      a_if.conv_done = vecs[i].mask;
      a_if.conv_data = mk_data(ADC_PWM, vecs[i].data);
      @(negedge clk);
      a_if.conv_done = '0;
      if (vecs[i].exp_valid) exp_last = vecs[i].data;
      check($sformatf("vec%0d valid", i), a_if.sample_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d data", i), a_if.sample_data, exp_last);
      check($sformatf("vec%0d src", i), a_if.sample_src, 0);
      if (!vecs[i].exp_valid) begin
        repeat (48 - vecs[i].delay) @(negedge clk);
        check($sformatf("vec%0d timeout before", i), a_if.timeout_err, 0);
        @(negedge clk);
        check($sformatf("vec%0d timeout at 50", i), a_if.timeout_err, 1);
      end
      if (!a_if.conv_start) wait_sig(0, 200, n);
      check($sformatf("vec%0d start interval", i), cyc - t_start, 100);
      t_start = cyc;
    end
    check("timeout sticky", a_if.timeout_err, 1);

    // ---- switch PWM -> SAR during WAIT_DONE ----
    repeat (5) @(negedge clk);
    a_if.adc_sel = 2'd2;
    @(negedge clk);
    check("pwm_en 1 cycle after sel", a_if.pwm_en, 1);
    @(negedge clk);
    check("pwm_en 2 cycles after sel", a_if.pwm_en, 0);
    check("no valid on abort", a_if.sample_valid, 0);
    n = 0;
    vseen = 1'b0;
    while (!a_if.sar_en && n < 40) begin
      if (n == 3) a_if.adc_sel = 2'd3;   // reselect inside guard: no restart
      if (n == 8) begin
        a_if.adc_sel   = 2'd2;
        a_if.conv_done = 4'b0101;        // late PWM done and SAR done in guard
      end
      if (n == 9) a_if.conv_done = '0;
      @(negedge clk);
      n++;
      vseen |= a_if.sample_valid;
    end
    a_if.conv_done = '0;
    check("sar_en after guard", n, 16);
    check("no valid during guard", vseen, 0);
    check("only sar enabled", {a_if.pwm_en, a_if.r2r_en, a_if.sar_en, a_if.xadc_en}, 4'b0010);

    wait_sig(0, 1100, n);
    check("sar first start", n, 1000);
    repeat (5) @(negedge clk);
    a_if.conv_done = 4'b0101;
    a_if.conv_data = mk_data(ADC_SAR, 12'h9A5);
    @(negedge clk);
    a_if.conv_done = '0;
    check("sar valid", a_if.sample_valid, 1);
    check("sar data", a_if.sample_data, 12'h9A5);
    check("sar src", a_if.sample_src, 2);
    check("timeout sticky after switch", a_if.timeout_err, 1);

    // ---- late done on dut_b: done 150 cycles after start ----
    wait_sig(3, 1200, n);
    check("b start found", n < 1200, 1);
    t_start = cyc;
    repeat (150) @(negedge clk);
    b_if.conv_done = 4'b0001;
    b_if.conv_data = mk_data(ADC_PWM, 12'h3C3);
    @(negedge clk);
    b_if.conv_done = '0;
    check("b late valid", b_if.sample_valid, 1);
    check("b late data", b_if.sample_data, 12'h3C3);
    check("b start right after capture", b_if.conv_start, 1);
    check("b late start offset", cyc - t_start, 151);
    t2 = cyc;
    @(negedge clk);
    check("b single start", b_if.conv_start, 0);
    repeat (9) @(negedge clk);
    b_if.conv_done = 4'b0001;
    b_if.conv_data = mk_data(ADC_PWM, 12'h246);
    @(negedge clk);
    b_if.conv_done = '0;
    check("b next valid", b_if.sample_valid, 1);
    check("b next data", b_if.sample_data, 12'h246);
    wait_sig(3, 200, n);
    check("b interval after late", cyc - t2, 100);

    // ---- asynchronous reset between clock edges ----
    reset = 1'b0;
    #1;
    check("async rst enables", {a_if.pwm_en, a_if.r2r_en, a_if.sar_en, a_if.xadc_en}, 0);
    check("async rst timeout_err", a_if.timeout_err, 0);
    check("async rst busy", a_if.busy, 1);
    check("async rst sample_data", a_if.sample_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_conv_scheduler.md
# adc_conv_scheduler

Conversion scheduler between the menu subsystem and the four ADC front-ends (PWM, R2R, SAR, XADC). It takes the menu's `adc_sel` and drives exactly one ADC enable at a time, with a dead-time guard and settling delay on every switch. It issues periodic conversion-start pulses to the active ADC and collects its result, with a timeout. It presents one sample stream (data, source tag, valid pulse) to the scaling/display path.

## Interface
- `SAMPLE_PERIOD`, 100_000: cycles between consecutive `conv_start` pulses; minimum 2.
- `GUARD_CYCLES`, 16: cycles with all enables low on every ADC switch; minimum 1.
- `SETTLE_CYCLES`, 1_000: cycles with the new enable high before the first start; minimum 1.
- `TIMEOUT_CYCLES`, 50_000: maximum wait for `conv_done` after a start.
- `DATA_W`, 12: sample width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `adc_sel` in 2: from the menu; 0=PWM, 1=R2R, 2=SAR, 3=XADC.
- `conv_done` in 4: per-ADC completion pulse; bit index equals the `adc_sel` code.
- `conv_data` in 4*DATA_W: per-ADC result; slice i corresponds to ADC i.
- `pwm_en`, `r2r_en`, `sar_en`, `xadc_en` out 1 each: ADC enables; at most one is high at any time.
- `conv_start` out 1: one-cycle start pulse to the enabled ADC.
- `sample_data` out DATA_W: captured result.
- `sample_src` out 2: ADC code of `sample_data`.
- `sample_valid` out 1: one-cycle qualifier for `sample_data`/`sample_src`.
- `timeout_err` out 1: sticky; cleared only by reset.
- `busy` out 1: high in GUARD, SETTLE and WAIT_DONE.

## Operation
- `adc_sel` is registered once (`sel_q`). The active ADC is `act`.
- States are GUARD, SETTLE, WAIT_PERIOD, START and WAIT_DONE.
- GUARD: all enables low. Load `GUARD_CYCLES`. On expiry, set `act` = `sel_q` and go to SETTLE.
- SETTLE: `act` enable high. On expiry of `SETTLE_CYCLES`, go to START.
- START: `conv_start` = 1 for one cycle. Reload the period counter with `SAMPLE_PERIOD` and the timeout counter with `TIMEOUT_CYCLES`. Go to WAIT_DONE.
- WAIT_DONE, when `conv_done[act]`: capture `conv_data[act]`; set `sample_src` = `act`. Go to START if the period counter has expired, otherwise to WAIT_PERIOD.
- WAIT_DONE, on timeout expiry: set `timeout_err`. No valid is produced. Same onward transition as above.
- WAIT_PERIOD: go to START when the period counter expires. Only one start is owed no matter how late the done arrived; starts never accumulate.
- `conv_done` bits other than `act` are ignored in all states. `conv_done` seen outside WAIT_DONE is ignored.
- `sel_q` != `act` in SETTLE, WAIT_PERIOD, START or WAIT_DONE: abort to GUARD next cycle. Enables drop on that same edge and any in-flight result is discarded.
- `adc_sel` changes during GUARD: no restart. The latest `sel_q` is taken at guard expiry.

## Timing
- Reset values: all enables 0, `conv_start` 0, `sample_data` 0, `sample_src` 0, `sample_valid` 0, `timeout_err` 0, `busy` 1. State = GUARD with the guard count loaded, `act` = 0.
- Enables change only on GUARD entry and exit, so the dead time is at least `GUARD_CYCLES` cycles.
- `sample_valid` is registered and rises the cycle after `conv_done[act]` is sampled. `sample_data` is stable while valid is high.
- Consecutive `conv_start` rising edges are exactly `SAMPLE_PERIOD` cycles apart when done returns in time.
- From `adc_sel` change in steady state to the new enable high: 1 (register) + 1 (abort) + `GUARD_CYCLES` cycles.
- Reset assertion mid-conversion clears everything asynchronously. No valid is produced for the aborted conversion.

## Configuration
- `ADC_SCHED_AVG_EN` defined: each valid conversion adds into a DATA_W+2 accumulator.
  - Every 4th conversion pulses `sample_valid` with `sample_data` = sum >> 2 (truncated).
  - The accumulator and count are cleared on GUARD entry and on timeout.
- `ADC_SCHED_AVG_EN` undefined: every conversion is output directly. No accumulator logic is present.

## Structure
- `adc_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - the `adc_id_t` enum with PWM=0, R2R=1, SAR=2, XADC=3, shared with the menu FSM;
  - the localparam `NUM_ADC` = 4.
- One sub-module, `sched_timer`: a loadable down-counter with an expiry flag, instantiated three times (guard/settle, period, timeout).

## Test plan
- Reset release with `adc_sel`=0 and GUARD=16, SETTLE=1000 -> `pwm_en` rises 16 cycles after reset. First `conv_start` comes 1000 cycles later.
- PERIOD=100 with done 10 cycles after each start and data 0xABC -> starts every 100 cycles; `sample_valid` the cycle after done with `sample_data`=0xABC and `sample_src`=0.
- Switch `adc_sel` 0->2 during WAIT_DONE -> `pwm_en` low 2 cycles later with no valid. `sar_en` rises 16 cycles after that; the late PWM done is ignored.
- No done with TIMEOUT=50 -> `timeout_err` set 50 cycles after start and stays set. The next start still follows 100 cycles after the previous one.
- Done at cycle 150 with PERIOD=100 -> the next start is 1 cycle after the capture, with no double start. `conv_done` pulses on non-active bits -> no valid.
- `ADC_SCHED_AVG_EN` with data 10, 11, 12, 13 -> a single valid with `sample_data`=11.
